mips_alu_mc: RTL and testbench
==============================

MIPS_ALU_MC -- requirements
Module: mips_alu_mc

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width; it is derived and not overridden.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port in_valid, input, 1 bit: the operand/opcode bundle is valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept a bundle.
REQ-007 Port rs, input, WIDTH bits: operand A.
REQ-008 Port rt, input, WIDTH bits: operand B; rt[SHW-1:0] is the shift amount.
REQ-009 Port op, input, 4 bits: opcode.
REQ-010 Port out_valid, output, 1 bit: the result bundle is valid.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 Port aluresult, output, WIDTH bits: the result.
REQ-013 Port zero, output, 1 bit: aluresult == 0.
REQ-014 Port ovf, output, 1 bit: signed overflow on ADD/SUB; 0 for all other ops.
REQ-015 Port err, output, 1 bit: illegal opcode, or divide by zero.

Function
REQ-016 Opcodes SHALL be:
- 0000 AND, bitwise.
- 0001 OR, bitwise.
- 0010 ADD.
- 0011 SUB.
- 0100 SLT, signed.
- 0101 SLTU.
- 0110 XOR.
- 0111 NOR.
- 1000 SLL.
- 1001 SRL.
- 1010 SRA.
- 1011 MUL, low WIDTH bits, unsigned.
- 1100 DIVU, quotient.
- 1101 REMU.
- 1110 and 1111 are illegal.
REQ-017 ADD, SUB and MUL SHALL wrap modulo 2^WIDTH; SLT and SLTU SHALL return 1 zero-extended, or 0.
REQ-018 ovf SHALL be 1 when the operand signs match and the result sign differs (ADD), or when the operand signs differ and the result sign differs from rs (SUB).
REQ-019 Shifts SHALL use only rt[SHW-1:0]; SRA SHALL replicate rs[WIDTH-1].
REQ-020 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-021 in_ready SHALL equal (state == IDLE).
REQ-022 A bundle SHALL be accepted on a rising edge with in_valid && in_ready; operands and op SHALL be registered at that edge.
REQ-023 For single-cycle ops (0000-1010, and illegal opcodes), accept SHALL move IDLE -> DONE, and out_valid SHALL be 1 in the first cycle after accept.
REQ-024 For MUL/DIVU/REMU, accept SHALL move IDLE -> BUSY. A shift-add (MUL) or restoring (DIVU/REMU) engine SHALL run exactly WIDTH iterations using a counter. The FSM SHALL then move BUSY -> DONE, and out_valid SHALL rise WIDTH+1 cycles after accept.
REQ-025 In DONE:
- out_valid = 1.
- aluresult, zero, ovf and err SHALL be held stable until out_valid && out_ready.
- On out_valid && out_ready the FSM SHALL move to IDLE.
REQ-026 in_valid while BUSY or DONE SHALL be ignored, because in_ready = 0.
REQ-027 Illegal opcodes SHALL give aluresult = 0 and err = 1, with single-cycle latency.
REQ-028 DIVU with rt = 0 SHALL give an all-ones quotient; REMU with rt = 0 SHALL give remainder = rs. Both SHALL set err = 1, and latency stays WIDTH+1.
REQ-029 zero SHALL be computed from the final result, for every op.
REQ-030 When out_valid = 0, the outputs aluresult, zero, ovf and err SHALL be 0.

Reset
REQ-031 rst_n low SHALL immediately force:
- state to IDLE;
- the iteration counter to 0;
- in_ready to 1 (after release);
- out_valid, aluresult, zero, ovf and err to 0.
REQ-032 Reset asserted mid-BUSY or mid-DONE SHALL abort the operation; no result SHALL be produced after release.
REQ-033 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-034 ADD with WIDTH=32: rs=7FFFFFFF, rt=00000001 -> aluresult=80000000, ovf=1, zero=0, with out_valid one cycle after accept.
REQ-035 SUB: rs=rt=12345678 -> aluresult=0, zero=1, ovf=0; SLT: rs=FFFFFFFF, rt=1 -> 1; SLTU with the same operands -> 0.
REQ-036 MUL: rs=0000FFFF, rt=00010001 -> aluresult=FFFFFFFF. out_valid SHALL rise exactly 33 cycles after accept, and in_ready SHALL be 0 throughout.
REQ-037 DIVU: rs=100, rt=0 -> aluresult=FFFFFFFF, err=1; REMU: rs=100, rt=7 -> aluresult=2, err=0.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0; then pulse out_ready -> IDLE on the next edge.
REQ-039 Reset mid-MUL (cycle 10 of 32) -> out_valid=0 immediately, in_ready=1 after release, and no stale result appears; op=1110 -> aluresult=0, err=1.

Source files
------------

// File: rtl/mips_alu_mc.sv
// mips_alu_mc: multi-cycle MIPS-style ALU with a valid/ready handshake on
// both sides. Logic/arithmetic/shift/compare ops finish in one cycle; MUL,
// DIVU and REMU run a bit-serial engine for exactly WIDTH iterations.
// The IDLE/BUSY/DONE FSM owns every output, and all outputs are registered.

module mips_alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluresult,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    // ------------------------------------------------------------------
    // Opcode map
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    // Counter value of the final engine iteration.
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Result bundle produced by the single-cycle datapath.
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             ovf;
        logic             err;
    } sc_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // True for the opcodes handled by the iterative engine.
    function automatic logic is_multi(input logic [3:0] f_op);
        logic m;
        case (f_op)
            OP_MUL, OP_DIVU, OP_REMU: m = 1'b1;
            default:                  m = 1'b0;
        endcase
        return m;
    endfunction

    // Whole single-cycle ALU; illegal opcodes return zero with err set.
    function automatic sc_t alu_single(input logic [3:0]       f_op,
                                       input logic [WIDTH-1:0] f_a,
                                       input logic [WIDTH-1:0] f_b);
        sc_t              r;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] dif;
        logic [SHW-1:0]   sh;
        r   = '0;
        sum = f_a + f_b;
        dif = f_a - f_b;
        sh  = f_b[SHW-1:0];
        case (f_op)
            OP_AND:  r.res = f_a & f_b;
            OP_OR:   r.res = f_a | f_b;
            OP_ADD: begin
                r.res = sum;
                r.ovf = (f_a[WIDTH-1] == f_b[WIDTH-1]) &&
                        (sum[WIDTH-1] != f_a[WIDTH-1]);
            end
            OP_SUB: begin
                r.res = dif;
                r.ovf = (f_a[WIDTH-1] != f_b[WIDTH-1]) &&
                        (dif[WIDTH-1] != f_a[WIDTH-1]);
            end
            OP_SLT:  r.res = {{(WIDTH-1){1'b0}}, ($signed(f_a) < $signed(f_b))};
            OP_SLTU: r.res = {{(WIDTH-1){1'b0}}, (f_a < f_b)};
            OP_XOR:  r.res = f_a ^ f_b;
            OP_NOR:  r.res = ~(f_a | f_b);
            OP_SLL:  r.res = f_a << sh;
            OP_SRL:  r.res = f_a >> sh;
            OP_SRA:  r.res = WIDTH'($signed(f_a) >>> sh);
            default: begin
                r.res = '0;
                r.err = 1'b1;
            end
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_r;
    logic [SHW-1:0]   cnt_r;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] a_r;        // MUL: shifted multiplicand, DIV: dividend/quotient
    logic [WIDTH-1:0] b_r;        // MUL: shifted multiplier,   DIV: divisor
    logic [WIDTH-1:0] acc_r;      // MUL: partial product,      DIV: partial remainder
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] aluresult_r;
    logic             zero_r;
    logic             ovf_r;
    logic             err_r;

    // ------------------------------------------------------------------
    // Combinational datapaths
    // ------------------------------------------------------------------
    sc_t              sc_s;
    logic [WIDTH-1:0] mul_acc_nx_s;
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   rem_sub_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] rem_nx_s;
    logic [WIDTH-1:0] quo_nx_s;
    logic [WIDTH-1:0] mc_res_s;
    logic             mc_err_s;

    // Single-cycle result straight from the input bundle, loaded on accept.
    always_comb begin
        sc_s = alu_single(op, rs, rt);
    end

    // One engine step: shift-add for MUL, restoring step for DIVU/REMU.
    // A zero divisor always passes the trial subtraction, which yields an
    // all-ones quotient and leaves the dividend as the remainder.
    always_comb begin
        if (b_r[0]) begin
            mul_acc_nx_s = acc_r + a_r;
        end else begin
            mul_acc_nx_s = acc_r;
        end
        rem_shift_s = {acc_r, a_r[WIDTH-1]};
        rem_sub_s   = rem_shift_s - {1'b0, b_r};
        div_ge_s    = (rem_shift_s >= {1'b0, b_r});
        if (div_ge_s) begin
            rem_nx_s = rem_sub_s[WIDTH-1:0];
        end else begin
            rem_nx_s = rem_shift_s[WIDTH-1:0];
        end
        quo_nx_s = {a_r[WIDTH-2:0], div_ge_s};
    end

    // Final engine result, valid on the last iteration.
    always_comb begin
        case (op_r)
            OP_MUL:  mc_res_s = mul_acc_nx_s;
            OP_DIVU: mc_res_s = quo_nx_s;
            OP_REMU: mc_res_s = rem_nx_s;
            default: mc_res_s = '0;
        endcase
        if ((op_r == OP_DIVU) || (op_r == OP_REMU)) begin
            mc_err_s = (b_r == '0);
        end else begin
            mc_err_s = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM, engine registers and registered outputs
    // ------------------------------------------------------------------

    // FSM: accept in IDLE, iterate in BUSY, hold the result in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= '0;
            op_r        <= 4'b0000;
            a_r         <= '0;
            b_r         <= '0;
            acc_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            aluresult_r <= '0;
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r       <= op;
                        a_r        <= rs;
                        b_r        <= rt;
                        acc_r      <= '0;
                        cnt_r      <= '0;
                        in_ready_r <= 1'b0;
                        if (is_multi(op)) begin
                            state_r <= S_BUSY;
                        end else begin
                            state_r     <= S_DONE;
                            out_valid_r <= 1'b1;
                            aluresult_r <= sc_s.res;
                            zero_r      <= (sc_s.res == '0);
                            ovf_r       <= sc_s.ovf;
                            err_r       <= sc_s.err;
                        end
                    end
                end
                S_BUSY: begin
                    if (op_r == OP_MUL) begin
                        acc_r <= mul_acc_nx_s;
                        a_r   <= {a_r[WIDTH-2:0], 1'b0};
                        b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    end else begin
                        acc_r <= rem_nx_s;
                        a_r   <= quo_nx_s;
                    end
                    if (cnt_r == CNT_LAST) begin
                        cnt_r       <= '0;
                        state_r     <= S_DONE;
                        out_valid_r <= 1'b1;
                        aluresult_r <= mc_res_s;
                        zero_r      <= (mc_res_s == '0);
                        ovf_r       <= 1'b0;
                        err_r       <= mc_err_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_r     <= S_IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        aluresult_r <= '0;
                        zero_r      <= 1'b0;
                        ovf_r       <= 1'b0;
                        err_r       <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    cnt_r       <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    aluresult_r <= '0;
                    zero_r      <= 1'b0;
                    ovf_r       <= 1'b0;
                    err_r       <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign aluresult = aluresult_r;
    assign zero      = zero_r;
    assign ovf       = ovf_r;
    assign err       = err_r;

endmodule

// File: tb/tb_mips_alu_mc.sv
// Bench for mips_alu_mc (WIDTH=32): directed vectors with literal expected
// values, plus a transaction-level reference model checked every cycle.

module tb_mips_alu_mc;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] aluresult;
    logic        zero;
    logic        ovf;
    logic        err;

    int checks   = 0;
    int failures = 0;

    mips_alu_mc #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs        (rs),
        .rt        (rt),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluresult (aluresult),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {result, zero, ovf, err} from plain integer maths.
    function automatic logic [34:0] model_calc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      s;
        logic [31:0] r;
        logic        v;
        logic        e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 32'h0;
        v  = 1'b0;
        e  = 1'b0;
        case (o)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin s = sa + sb; r = 32'(s); v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd3:  begin s = sa - sb; r = 32'(s); v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd4:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd5:  r = (a < b) ? 32'd1 : 32'd0;
            4'd6:  r = a ^ b;
            4'd7:  r = ~(a | b);
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd10: r = 32'(sa >>> b[4:0]);
            4'd11: r = 32'(64'(a) * 64'(b));
            4'd12: begin if (b == 32'd0) begin r = 32'hFFFFFFFF; e = 1'b1; end else r = a / b; end
            4'd13: begin if (b == 32'd0) begin r = a; e = 1'b1; end else r = a % b; end
            default: begin r = 32'h0; e = 1'b1; end
        endcase
        return {r, (r == 32'h0), v, e};
    endfunction

    // Transaction model: idle / waiting for a multi-cycle result / holding a result.
    bit          m_valid = 1'b0;
    bit          m_pend  = 1'b0;
    int          m_wait  = 0;
    logic [34:0] m_exp   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_pend  <= 1'b0;
            m_wait  <= 0;
            m_exp   <= '0;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (m_pend) begin
            if (m_wait == 1) begin
                m_pend  <= 1'b0;
                m_valid <= 1'b1;
            end
            m_wait <= m_wait - 1;
        end else if (in_valid) begin
            m_exp <= model_calc(op, rs, rt);
            if (op == 4'd11 || op == 4'd12 || op == 4'd13) begin
                m_pend <= 1'b1;
                m_wait <= WIDTH;
            end else begin
                m_valid <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(!m_valid && !m_pend));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("outputs", {29'h0, aluresult, zero, ovf, err}, m_valid ? {29'h0, m_exp} : 64'h0);
    end

    // Drive one bundle, measure latency, optionally backpressure, then retire.
    task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eres, input logic eerr, input int elat,
                       input int hold, input bit nowait, input bit spam);
        int lat;
        if (!nowait) @(negedge clk);
        rs = a; rt = b; op = o; in_valid = 1'b1;
        @(posedge clk); #1;
        if (spam) begin
            op = 4'd0; rs = 32'h0; rt = 32'h0;
        end else begin
            in_valid = 1'b0;
        end
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(elat));
        chk("result", 64'(aluresult), 64'(eres));
        chk("err", 64'(err), 64'(eerr));
        repeat (hold) @(posedge clk);
        #1;
        chk("held_result", 64'(aluresult), 64'(eres));
        chk("held_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("retire_valid", 64'(out_valid), 64'd0);
        chk("retire_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        rs = 32'h0; rt = 32'h0; op = 4'h0;

        // Pin the reference model against hand-computed values.
        chk("model_add", 64'(model_calc(4'd2, 32'h7FFFFFFF, 32'h1)), 64'({32'h80000000, 1'b0, 1'b1, 1'b0}));
        chk("model_sub", 64'(model_calc(4'd3, 32'h12345678, 32'h12345678)), 64'({32'h0, 1'b1, 1'b0, 1'b0}));
        chk("model_slt", 64'(model_calc(4'd4, 32'hFFFFFFFF, 32'h1)), 64'({32'h1, 1'b0, 1'b0, 1'b0}));
        chk("model_mul", 64'(model_calc(4'd11, 32'h0000FFFF, 32'h00010001)), 64'({32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}));
        chk("model_div0", 64'(model_calc(4'd12, 32'd100, 32'd0)), 64'({32'hFFFFFFFF, 1'b0, 1'b0, 1'b1}));
        chk("model_remu", 64'(model_calc(4'd13, 32'd100, 32'd7)), 64'({32'd2, 1'b0, 1'b0, 1'b0}));

        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", {29'h0, aluresult, zero, ovf, err}, 64'h0);

        // Release and accept on the very first edge.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(4'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1, 0, 1'b1, 1'b0);

        run(4'd3, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1, 0, 1'b0, 1'b0);
        run(4'd3, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1, 0, 1'b0, 1'b0);
        run(4'd4, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1, 0, 1'b0, 1'b0);
        run(4'd5, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1, 0, 1'b0, 1'b0);
        run(4'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1, 5, 1'b0, 1'b0);
        run(4'd1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1, 0, 1'b0, 1'b0);
        run(4'd6, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1, 0, 1'b0, 1'b0);
        run(4'd7, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1, 0, 1'b0, 1'b0);
        run(4'd8, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0, 1, 0, 1'b0, 1'b0);
        run(4'd9, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1, 0, 1'b0, 1'b0);
        run(4'd10, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1, 0, 1'b0, 1'b0);
        run(4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1, 0, 1'b0, 1'b0);
        run(4'd11, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 33, 5, 1'b0, 1'b1);
        run(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33, 0, 1'b0, 1'b0);
        run(4'd12, 32'd100, 32'd0, 32'hFFFFFFFF, 1'b1, 33, 0, 1'b0, 1'b0);
        run(4'd12, 32'd100, 32'd7, 32'd14, 1'b0, 33, 0, 1'b0, 1'b0);
        run(4'd13, 32'd100, 32'd7, 32'd2, 1'b0, 33, 0, 1'b0, 1'b0);
        run(4'd13, 32'd100, 32'd0, 32'd100, 1'b1, 33, 0, 1'b0, 1'b0);

        // Reset in the middle of a MUL: no result may survive.
        @(negedge clk);
        rs = 32'h0000FFFF; rt = 32'h00010001; op = 4'd11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        chk("midrst_result", 64'(aluresult), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(4'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 0, 1'b1, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        chk("no_stale", 64'(out_valid), 64'd0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
